// File: rtl/arcade_input_pkg.sv
// ----------------------------------------------------------------------------
// arcade_input_pkg
// Shared constants, the PS/2 keymap and the control vector bit layout for
// the arcade player-input front end.
//
// Keymap slots use a fixed layout sized for the largest button count:
//   0 R, 1 L, 2 D, 3 U, 4..9 buttons 0..5, 10 start, 11 coin, 12 pause,
//   13 service.
// slot_for_bit() translates a control vector bit position for a given
// button count into this slot layout.
// ----------------------------------------------------------------------------
package arcade_input_pkg;

    localparam int MAX_PLAYERS = 4;
    localparam int MAX_BUTTONS = 6;
    localparam int NUM_SLOTS   = MAX_BUTTONS + 8;

    typedef logic [8:0] key_code_t;   // {extended, scan code}

    localparam key_code_t KEY_NONE = 9'h000;

    localparam int SLOT_R       = 0;
    localparam int SLOT_L       = 1;
    localparam int SLOT_D       = 2;
    localparam int SLOT_U       = 3;
    localparam int SLOT_BTN0    = 4;
    localparam int SLOT_START   = SLOT_BTN0 + MAX_BUTTONS;
    localparam int SLOT_COIN    = SLOT_START + 1;
    localparam int SLOT_PAUSE   = SLOT_START + 2;
    localparam int SLOT_SERVICE = SLOT_START + 3;

    typedef key_code_t keymap_t [MAX_PLAYERS][NUM_SLOTS];

    // P1: arrows, ctrl/alt/space, 1 start, 5 coin, p pause, 9 service.
    // P2: r/f/d/g, a/s/q, 2 start, 6 coin, p pause (shared), 0 service.
    localparam keymap_t KEYMAP = '{
        '{9'h174, 9'h16B, 9'h172, 9'h175,
          9'h014, 9'h011, 9'h029, 9'h000, 9'h000, 9'h000,
          9'h016, 9'h02E, 9'h04D, 9'h046},
        '{9'h034, 9'h023, 9'h02B, 9'h02D,
          9'h01C, 9'h01B, 9'h015, 9'h000, 9'h000, 9'h000,
          9'h01E, 9'h036, 9'h04D, 9'h045},
        '{default: KEY_NONE},
        '{default: KEY_NONE}
    };

    // Control vector bit positions for a build with nb buttons.
    function automatic int bit_btn(input int b);
        return 4 + b;
    endfunction

    function automatic int bit_start(input int nb);
        return 4 + nb;
    endfunction

    function automatic int bit_coin(input int nb);
        return 5 + nb;
    endfunction

    function automatic int bit_pause(input int nb);
        return 6 + nb;
    endfunction

    function automatic int bit_service(input int nb);
        return 7 + nb;
    endfunction

    // Vector bit -> keymap slot, -1 when the bit has no slot.
    function automatic int slot_for_bit(input int nb, input int b);
        if (b < 4)                 return b;
        if (b < 4 + nb)            return b;
        if (b == bit_start(nb))    return SLOT_START;
        if (b == bit_coin(nb))     return SLOT_COIN;
        if (b == bit_pause(nb))    return SLOT_PAUSE;
        if (b == bit_service(nb))  return SLOT_SERVICE;
        return -1;
    endfunction

    // Keymap entry for player p, vector bit b; KEY_NONE when unmapped.
    function automatic key_code_t keymap_code(input int p, input int nb, input int b);
        int slot;
        slot = slot_for_bit(nb, b);
        if (p < 0 || p >= MAX_PLAYERS || slot < 0) return KEY_NONE;
        return KEYMAP[p][slot];
    endfunction

endpackage

// File: rtl/arcade_input_ctrl_if.sv
// ----------------------------------------------------------------------------
// arcade_input_ctrl_if
// Bundle of the player-input signals between the host side (hps_io, test
// bench) and arcade_input_ctrl.
//   ps2_key     11             [10] toggle, [9] pressed, [8] ext, [7:0] code
//   joystick    32*NUM_PLAYERS  player p word at [32p +: 32]
//   autofire_en NP*NB           per-button autofire enable
//                               (present only with ARCADE_INPUT_AUTOFIRE_EN)
//   player      PW*NUM_PLAYERS  conditioned controls, PW = NUM_BUTTONS+8
// Modports: master drives the inputs, slave is the controller.
// ----------------------------------------------------------------------------
interface arcade_input_ctrl_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_BUTTONS = 3
);
    localparam int PW = NUM_BUTTONS + 8;

    logic [10:0]                 ps2_key;
    logic [32*NUM_PLAYERS-1:0]   joystick;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    logic [NUM_PLAYERS*NUM_BUTTONS-1:0] autofire_en;
`endif
    logic [PW*NUM_PLAYERS-1:0]   player;

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    modport master (output ps2_key, output joystick, output autofire_en, input player);
    modport slave  (input ps2_key, input joystick, input autofire_en, output player);
`else
    modport master (output ps2_key, output joystick, input player);
    modport slave  (input ps2_key, input joystick, output player);
`endif

endinterface

// File: rtl/arcade_pulse_stretch.sv
// ----------------------------------------------------------------------------
// arcade_pulse_stretch
// Stretches a level so that every rising edge produces at least CYCLES
// cycles of high output. dout_o = din_i | (count != 0); a rising edge
// (re)loads the count with CYCLES-1, which then decrements to 0.
// Ports:
//   clk_sys  in  system clock
//   RESET    in  asynchronous active-high reset
//   din_i    in  raw level
//   dout_o   out stretched level (combinational, registered by the parent)
// ----------------------------------------------------------------------------
module arcade_pulse_stretch #(
    parameter int CYCLES = 1
) (
    input  logic clk_sys,
    input  logic RESET,
    input  logic din_i,
    output logic dout_o
);
    localparam int CW = $clog2(CYCLES + 1);

    logic          din_prev_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (din_i && !din_prev_q) begin
            cnt_d = CW'(CYCLES - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            din_prev_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            din_prev_q <= din_i;
            cnt_q      <= cnt_d;
        end
    end

    assign dout_o = din_i | (cnt_q != '0);

endmodule

// File: rtl/arcade_input_ctrl.sv
// ----------------------------------------------------------------------------
// arcade_input_ctrl
// Player-input front end: decodes PS/2 key events into held-key state,
// OR-merges with the MiSTer joystick words, applies SOCD cleaning, coin
// stretching and (optionally) autofire, and registers one control vector
// per player.
// Vector layout: [0]R [1]L [2]D [3]U [4+:NB]buttons [4+NB]start
//                [5+NB]coin [6+NB]pause [7+NB]service
// Ports:
//   clk_sys  in  system clock
//   RESET    in  asynchronous active-high reset
//   bus      arcade_input_ctrl_if.slave (ps2_key, joystick, [autofire_en],
//            player)
// Optional feature macro: ARCADE_INPUT_AUTOFIRE_EN (autofire divider and
// the autofire_en input).
// ----------------------------------------------------------------------------
module arcade_input_ctrl
    import arcade_input_pkg::*;
#(
    parameter int NUM_PLAYERS       = 2,
    parameter int NUM_BUTTONS       = 3,
    parameter int COIN_PULSE_CYCLES = 1 << 20,
    parameter int SOCD_MODE         = 1,
    parameter int AUTOFIRE_HALF     = 1 << 19
) (
    input logic             clk_sys,
    input logic             RESET,
    arcade_input_ctrl_if.slave bus
);
    localparam int PW       = NUM_BUTTONS + 8;
    localparam int BIT_COIN = bit_coin(NUM_BUTTONS);

    // ------------------------------------------------------------------
    // PS/2 event detection and held-key state
    // ------------------------------------------------------------------
    logic      tog_q;
    logic      primed_q;
    logic      ps2_evt;
    key_code_t ps2_code;

    logic [PW-1:0] key_q [NUM_PLAYERS];
    logic [PW-1:0] key_d [NUM_PLAYERS];

    assign ps2_code = {bus.ps2_key[8], bus.ps2_key[7:0]};
    // The first cycle after reset only captures the toggle level, so a
    // toggle left high by the host is not mistaken for a fresh event.
    assign ps2_evt  = primed_q && (bus.ps2_key[10] != tog_q);

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            tog_q    <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            tog_q    <= bus.ps2_key[10];
            primed_q <= 1'b1;
        end
    end

    // Every matching entry is updated, so one code may drive several bits.
    always_comb begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            key_d[p] = key_q[p];
            if (ps2_evt) begin
                for (int b = 0; b < PW; b++) begin
                    if (keymap_code(p, NUM_BUTTONS, b) != KEY_NONE &&
                        keymap_code(p, NUM_BUTTONS, b) == ps2_code) begin
                        key_d[p][b] = bus.ps2_key[9];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            for (int p = 0; p < NUM_PLAYERS; p++) key_q[p] <= '0;
        end else begin
            for (int p = 0; p < NUM_PLAYERS; p++) key_q[p] <= key_d[p];
        end
    end

    // ------------------------------------------------------------------
    // Autofire phase divider
    // ------------------------------------------------------------------
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    localparam int AF_W = (AUTOFIRE_HALF > 1) ? $clog2(AUTOFIRE_HALF) : 1;

    logic [AF_W-1:0] af_cnt_q;
    logic            af_phase_q;

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            af_cnt_q   <= '0;
            af_phase_q <= 1'b0;
        end else if (af_cnt_q == AF_W'(AUTOFIRE_HALF - 1)) begin
            af_cnt_q   <= '0;
            af_phase_q <= ~af_phase_q;
        end else begin
            af_cnt_q   <= af_cnt_q + 1'b1;
        end
    end
`else
    localparam int unused_af_half = AUTOFIRE_HALF;
`endif

    // ------------------------------------------------------------------
    // Per-player merge, SOCD, coin stretch, autofire
    // ------------------------------------------------------------------
    logic [PW*NUM_PLAYERS-1:0] player_d;
    logic [PW*NUM_PLAYERS-1:0] player_q;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        logic [PW-1:0] raw;
        logic [PW-1:0] cond;
        logic          coin_out;
        logic          unused_joy_hi;

        assign raw           = key_q[p] | bus.joystick[32*p +: PW];
        assign unused_joy_hi = ^bus.joystick[32*p+PW +: 32-PW];

        arcade_pulse_stretch #(
            .CYCLES (COIN_PULSE_CYCLES)
        ) u_coin (
            .clk_sys (clk_sys),
            .RESET   (RESET),
            .din_i   (raw[BIT_COIN]),
            .dout_o  (coin_out)
        );

        always_comb begin
            cond = raw;
            if (SOCD_MODE == 1) begin
                if (raw[0] && raw[1]) begin
                    cond[0] = 1'b0;
                    cond[1] = 1'b0;
                end
                if (raw[2] && raw[3]) begin
                    cond[2] = 1'b0;
                    cond[3] = 1'b0;
                end
            end
            cond[BIT_COIN] = coin_out;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
            for (int b = 0; b < NUM_BUTTONS; b++) begin
                cond[4+b] = raw[4+b] &
                            (af_phase_q | ~bus.autofire_en[p*NUM_BUTTONS+b]);
            end
`endif
        end

        assign player_d[PW*p +: PW] = cond;
    end

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            player_q <= '0;
        end else begin
            player_q <= player_d;
        end
    end

    assign bus.player = player_q;

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// ----------------------------------------------------------------------------
// tb_arcade_input_ctrl
// Self-checking bench for arcade_input_ctrl (4 players, 3 buttons, 16-cycle
// coin stretch, SOCD on, autofire half-period 8 when
// ARCADE_INPUT_AUTOFIRE_EN is defined). A behavioural model tracks held keys
// from its own key table and the coin rule as "cycles since last rising
// edge", and predicts the output vector for every clock.
// ----------------------------------------------------------------------------
module tb_arcade_input_ctrl;
    localparam int NP   = 4;
    localparam int NB   = 3;
    localparam int PW   = NB + 8;
    localparam int COIN = 16;
    localparam int HALF = 8;

    localparam int BR = 0, BL = 1, BD = 2, BU = 3, BB0 = 4;
    localparam int BSTART = 4 + NB, BCOIN = 5 + NB, BPAUSE = 6 + NB, BSERV = 7 + NB;

    logic clk_sys = 1'b0;
    logic RESET   = 1'b1;
    always #5 clk_sys = ~clk_sys;

    arcade_input_ctrl_if #(.NUM_PLAYERS(NP), .NUM_BUTTONS(NB)) bus();

    arcade_input_ctrl #(
        .NUM_PLAYERS       (NP),
        .NUM_BUTTONS       (NB),
        .COIN_PULSE_CYCLES (COIN),
        .SOCD_MODE         (1),
        .AUTOFIRE_HALF     (HALF)
    ) dut (
        .clk_sys (clk_sys),
        .RESET   (RESET),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- reference model ----------------
    typedef struct { int p; int bitpos; logic [8:0] code; } map_t;
    map_t keymap[$];

    logic [PW-1:0]      held [NP];
    logic               m_tog;
    bit                 m_primed;
    logic               coin_prev [NP];
    int                 last_rise [NP];
    int                 edges;
    logic [PW*NP-1:0]   exp_player;

    task automatic add_map(input int p, input int b, input logic [8:0] c);
        map_t m;
        m.p = p; m.bitpos = b; m.code = c;
        keymap.push_back(m);
    endtask

    task automatic build_keymap();
        add_map(0, BR, 9'h174); add_map(0, BL, 9'h16B); add_map(0, BD, 9'h172); add_map(0, BU, 9'h175);
        add_map(0, BB0, 9'h014); add_map(0, BB0+1, 9'h011); add_map(0, BB0+2, 9'h029);
        add_map(0, BSTART, 9'h016); add_map(0, BCOIN, 9'h02E); add_map(0, BPAUSE, 9'h04D); add_map(0, BSERV, 9'h046);
        add_map(1, BR, 9'h034); add_map(1, BL, 9'h023); add_map(1, BD, 9'h02B); add_map(1, BU, 9'h02D);
        add_map(1, BB0, 9'h01C); add_map(1, BB0+1, 9'h01B); add_map(1, BB0+2, 9'h015);
        add_map(1, BSTART, 9'h01E); add_map(1, BCOIN, 9'h036); add_map(1, BPAUSE, 9'h04D); add_map(1, BSERV, 9'h045);
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            held[p]      = '0;
            coin_prev[p] = 1'b0;
            last_rise[p] = -1000000;
        end
        m_primed   = 1'b0;
        m_tog      = 1'b0;
        edges      = 0;
        exp_player = '0;
    endtask

    // Predict the output for the coming edge, advance one clock, sample #1 later.
    task automatic step();
        logic [PW*NP-1:0] nxt;
        logic [PW-1:0]    raw;
        logic [PW-1:0]    o;
        nxt = '0;
        for (int p = 0; p < NP; p++) begin
            raw = held[p] | bus.joystick[32*p +: PW];
            o   = raw;
            if (raw[BR] && raw[BL]) begin o[BR] = 1'b0; o[BL] = 1'b0; end
            if (raw[BU] && raw[BD]) begin o[BU] = 1'b0; o[BD] = 1'b0; end
            o[BCOIN] = raw[BCOIN] || ((edges - last_rise[p]) < COIN);
`ifdef ARCADE_INPUT_AUTOFIRE_EN
            for (int b = 0; b < NB; b++)
                if (bus.autofire_en[p*NB+b] && ((edges / HALF) % 2 == 0)) o[BB0+b] = 1'b0;
`endif
            nxt[PW*p +: PW] = o;
            if (raw[BCOIN] && !coin_prev[p]) last_rise[p] = edges;
            coin_prev[p] = raw[BCOIN];
        end
        if (m_primed && (bus.ps2_key[10] != m_tog))
            foreach (keymap[i])
                if (keymap[i].code == bus.ps2_key[8:0])
                    held[keymap[i].p][keymap[i].bitpos] = bus.ps2_key[9];
        m_tog    = bus.ps2_key[10];
        m_primed = 1'b1;
        edges++;
        @(posedge clk_sys);
        #1;
        exp_player = nxt;
    endtask

    task automatic ps2_event(input logic pressed, input logic [8:0] code);
        bus.ps2_key = {~bus.ps2_key[10], pressed, code};
    endtask

    task automatic apply_reset();
        RESET = 1'b1;
        #1;
        model_reset();
        repeat (2) @(posedge clk_sys);
        #1;
        RESET = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        // Toggle left high with a mapped, pressed code: must not register.
        bus.ps2_key  = {1'b1, 1'b1, 9'h175};
        bus.joystick = '0;
        apply_reset();
        checks++;
        if (bus.player !== '0) begin
            errors++; $display("FAIL reset_value: got %h want 0", bus.player);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (bus.player !== '0 || exp_player !== '0) begin
                errors++; $display("FAIL reset_no_spurious: got %h want 0", bus.player);
            end
        end
    endtask

    task automatic test_ps2_keys();
        ps2_event(1'b1, 9'h175);
        step();
        checks++;
        if (bus.player[BU] !== 1'b0) begin
            errors++; $display("FAIL ps2_latency1: got %b want 0", bus.player[BU]);
        end
        bus.ps2_key[10] = bus.ps2_key[10];
        step();
        checks++;
        if (bus.player !== 44'(1) << BU) begin
            errors++; $display("FAIL ps2_up_press: got %h want %h", bus.player, 44'(1) << BU);
        end
        ps2_event(1'b0, 9'h175);
        step(); step();
        checks++;
        if (bus.player !== '0) begin
            errors++; $display("FAIL ps2_up_release: got %h want 0", bus.player);
        end
        // Non-extended 0x75 is not the up arrow.
        ps2_event(1'b1, 9'h075);
        step(); step();
        checks++;
        if (bus.player !== '0) begin
            errors++; $display("FAIL ps2_ext_bit: got %h want 0", bus.player);
        end
        // Shared pause key maps to both players.
        ps2_event(1'b1, 9'h04D);
        step(); step();
        checks++;
        if (bus.player[BPAUSE] !== 1'b1 || bus.player[PW+BPAUSE] !== 1'b1 || bus.player !== exp_player) begin
            errors++; $display("FAIL ps2_multi_map: got %h want %h", bus.player, exp_player);
        end
        ps2_event(1'b0, 9'h04D);
        step(); step();
        checks++;
        if (bus.player !== '0) begin
            errors++; $display("FAIL ps2_multi_release: got %h want 0", bus.player);
        end
    endtask

    task automatic test_socd();
        bus.joystick = '0;
        bus.joystick[1:0] = 2'b11;
        step();
        checks++;
        if (bus.player[1:0] !== 2'b00) begin
            errors++; $display("FAIL socd_lr: got %b want 00", bus.player[1:0]);
        end
        bus.joystick[0] = 1'b0;
        step();
        checks++;
        if (bus.player[1:0] !== 2'b10) begin
            errors++; $display("FAIL socd_drop_r: got %b want 10", bus.player[1:0]);
        end
        // Up from keyboard, down from joystick cancel too.
        bus.joystick = '0;
        bus.joystick[BD] = 1'b1;
        ps2_event(1'b1, 9'h175);
        step(); step();
        checks++;
        if (bus.player[3:0] !== 4'b0000 || bus.player !== exp_player) begin
            errors++; $display("FAIL socd_ud_mixed: got %h want %h", bus.player, exp_player);
        end
        ps2_event(1'b0, 9'h175);
        bus.joystick = '0;
        step(); step();
        checks++;
        if (bus.player !== '0) begin
            errors++; $display("FAIL socd_clear: got %h want 0", bus.player);
        end
    endtask

    task automatic test_coin(input bit retrig, input int want);
        int high;
        high = 0;
        for (int i = 0; i < 40; i++) begin
            bus.joystick = '0;
            bus.joystick[BCOIN] = (i == 0) || (retrig && i == 10);
            step();
            if (bus.player[BCOIN] === 1'b1) high++;
            checks++;
            if (bus.player !== exp_player) begin
                errors++; $display("FAIL coin_cycle%0d: got %h want %h", i, bus.player, exp_player);
            end
        end
        checks++;
        if (high != want) begin
            errors++; $display("FAIL coin_length: got %0d want %0d", high, want);
        end
    endtask

    task automatic test_player4();
        bus.joystick = '0;
        bus.joystick[96+4] = 1'b1;
        step();
        checks++;
        if (bus.player !== (44'(1) << (3*PW + 4))) begin
            errors++; $display("FAIL p4_button0: got %h want %h", bus.player, 44'(1) << (3*PW + 4));
        end
        ps2_event(1'b1, 9'h07E);
        step(); step();
        checks++;
        if (bus.player !== (44'(1) << (3*PW + 4))) begin
            errors++; $display("FAIL unmapped_7e: got %h want %h", bus.player, 44'(1) << (3*PW + 4));
        end
        bus.joystick = '0;
        ps2_event(1'b1, 9'h01E);
        step(); step();
        checks++;
        if (bus.player !== (44'(1) << (PW + BSTART))) begin
            errors++; $display("FAIL p2_start_key: got %h want %h", bus.player, 44'(1) << (PW + BSTART));
        end
        ps2_event(1'b0, 9'h01E);
        step(); step();
    endtask

    task automatic test_random();
        logic [8:0] codes [16];
        codes = '{9'h174, 9'h16B, 9'h172, 9'h175, 9'h014, 9'h029, 9'h02E, 9'h04D,
                  9'h034, 9'h023, 9'h01C, 9'h036, 9'h045, 9'h07E, 9'h075, 9'h000};
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3) == 0)
                ps2_event(1'($urandom_range(1)), codes[$urandom_range(15)]);
            if ($urandom_range(2) == 0)
                for (int p = 0; p < NP; p++)
                    bus.joystick[32*p +: 32] = $urandom & $urandom & $urandom;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
            if ($urandom_range(15) == 0) bus.autofire_en = NP*NB'($urandom);
`endif
            step();
            checks++;
            if (bus.player !== exp_player) begin
                errors++; $display("FAIL random_cycle%0d: got %h want %h", i, bus.player, exp_player);
            end
        end
    endtask

    task automatic test_reset_midop();
        bus.joystick = '0;
        ps2_event(1'b1, 9'h014);
        bus.joystick[BCOIN] = 1'b1;
        step(); step();
        bus.joystick = '0;
        RESET = 1'b1;
        #1;
        checks++;
        if (bus.player !== '0) begin
            errors++; $display("FAIL reset_async: got %h want 0", bus.player);
        end
        model_reset();
        @(posedge clk_sys);
        #1;
        RESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.player !== '0 || exp_player !== '0) begin
                errors++; $display("FAIL reset_drops_keys: got %h want 0", bus.player);
            end
        end
    endtask

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    task automatic test_autofire();
        int high;
        bus.joystick = '0;
        bus.autofire_en = '0;
        apply_reset();
        bus.joystick[BB0] = 1'b1;
        bus.autofire_en[0] = 1'b1;
        high = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            if (bus.player[BB0] === 1'b1) high++;
            checks++;
            if (bus.player !== exp_player) begin
                errors++; $display("FAIL autofire_cycle%0d: got %h want %h", i, bus.player, exp_player);
            end
        end
        checks++;
        if (high != 16) begin
            errors++; $display("FAIL autofire_duty: got %0d want 16", high);
        end
        bus.autofire_en[0] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (bus.player[BB0] !== 1'b1) begin
                errors++; $display("FAIL autofire_off: got %b want 1", bus.player[BB0]);
            end
        end
        bus.joystick = '0;
    endtask
`endif

    initial begin
        bus.ps2_key  = '0;
        bus.joystick = '0;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
        bus.autofire_en = '0;
`endif
        build_keymap();
        model_reset();
        test_reset();
        test_ps2_keys();
        test_socd();
        test_coin(1'b0, 16);
        test_coin(1'b1, 26);
        test_player4();
        test_random();
        test_reset_midop();
`ifdef ARCADE_INPUT_AUTOFIRE_EN
        test_autofire();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
